store_set_predictor: RTL and testbench

Parametrised store-set memory-dependence predictor for the LSU dispatch stage. It replaces PC-less, Bloom-filter-driven dependency guessing with trained store sets:
- An SSIT (PC-indexed, confidence-qualified) maps loads and stores to a store-set ID (SSID).
- An LFST maps each SSID to the ROB tag of the last in-flight store in that set.
- Dispatching loads receive a registered prediction and a store tag to wait on.
- Both tables are trained by violation and false-dependency reports from the LSU and cleared periodically.

---
 rtl/store_set_predictor.sv | 245 ++++++++++++++++++++++++
 tb/tb_store_set_predictor.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_set_predictor.sv
// Store-set memory-dependence predictor.
// The SSIT maps load/store PCs to a store-set ID (SSID) with a confidence counter.
// The LFST maps each SSID to the ROB tag of the youngest in-flight store in that set.
// Lookups read both tables combinationally and register the result (1-cycle latency).
module store_set_predictor #(
  parameter int PC_WIDTH       = 32,
  parameter int SSIT_ENTRIES   = 256,
  parameter int NUM_SSIDS      = 64,
  parameter int TAG_WIDTH      = 6,
  parameter int CONF_WIDTH     = 4,
  parameter int CONF_THRESH    = 8,
  parameter int CLEAR_INTERVAL = 65536,
  localparam int IDX_W         = $clog2(SSIT_ENTRIES),
  localparam int SSID_W        = $clog2(NUM_SSIDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lk_valid,
  input  logic                 lk_is_load,
  input  logic [PC_WIDTH-1:0]  lk_pc,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  output logic                 rsp_valid,
  output logic [SSID_W-1:0]    rsp_ssid,
  output logic                 rsp_predict_dep,
  output logic [TAG_WIDTH-1:0] rsp_dep_tag,
  input  logic                 st_done_valid,
  input  logic [SSID_W-1:0]    st_done_ssid,
  input  logic [TAG_WIDTH-1:0] st_done_tag,
  input  logic                 viol_valid,
  input  logic [PC_WIDTH-1:0]  viol_load_pc,
  input  logic [PC_WIDTH-1:0]  viol_store_pc,
  input  logic                 fdep_valid,
  input  logic [PC_WIDTH-1:0]  fdep_load_pc,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_predictions,
  output logic [31:0]          stat_violations,
  output logic [31:0]          stat_clears
);

  localparam int CLR_W = (CLEAR_INTERVAL > 2) ? $clog2(CLEAR_INTERVAL) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST =
    CLR_W'((CLEAR_INTERVAL > 0) ? CLEAR_INTERVAL - 1 : 0);
  localparam logic [CONF_WIDTH:0] THRESH_EXT = (CONF_WIDTH+1)'(CONF_THRESH);

  // Folded PC hash: two adjacent IDX_W-bit fields above the word offset.
  function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_WIDTH-1:0] pc);
    return pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2];
  endfunction

  function automatic logic [CONF_WIDTH-1:0] conf_inc(input logic [CONF_WIDTH-1:0] c);
    return (&c) ? c : c + CONF_WIDTH'(1);
  endfunction

  // Table storage: valid bits need reset/flash-clear, payloads do not.
  logic [SSIT_ENTRIES-1:0] ssit_valid_reg;
  logic [SSID_W-1:0]       ssit_ssid_reg [SSIT_ENTRIES];
  logic [CONF_WIDTH-1:0]   ssit_conf_reg [SSIT_ENTRIES];
  logic [NUM_SSIDS-1:0]    lfst_valid_reg;
  logic [TAG_WIDTH-1:0]    lfst_tag_reg  [NUM_SSIDS];
  logic [SSID_W-1:0]       alloc_ptr_reg;
  logic [CLR_W-1:0]        clr_cnt_reg;

  logic                    rsp_valid_reg;
  logic [SSID_W-1:0]       rsp_ssid_reg;
  logic                    rsp_pred_reg;
  logic [TAG_WIDTH-1:0]    rsp_tag_reg;

  logic                    clear_now;

  // Lookup path (pre-update table contents).
  logic [IDX_W-1:0]        lk_idx;
  logic                    lk_hit;
  logic [SSID_W-1:0]       lk_ssid;
  logic [CONF_WIDTH-1:0]   lk_conf;
  logic                    lk_pred;
  logic                    st_disp;

  // Training path.
  logic [IDX_W-1:0]        l_idx, s_idx, f_idx;
  logic                    l_valid, s_valid;
  logic [SSID_W-1:0]       l_ssid, s_ssid;
  logic [CONF_WIDTH-1:0]   l_conf, s_conf, f_conf;
  logic [SSID_W-1:0]       viol_ssid;
  logic [CONF_WIDTH-1:0]   l_conf_new, s_conf_new, f_conf_dec;
  logic                    alloc_take;
  logic                    fdep_act;
  logic                    sd_match;

  // Every PC bit is consumed by the hash or deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc, viol_load_pc, viol_store_pc, fdep_load_pc};

  assign clear_now = (CLEAR_INTERVAL != 0) && (clr_cnt_reg == CLR_LAST);

  assign lk_idx  = pc_idx(lk_pc);
  assign lk_hit  = ssit_valid_reg[lk_idx];
  assign lk_ssid = ssit_ssid_reg[lk_idx];
  assign lk_conf = ssit_conf_reg[lk_idx];
  assign lk_pred = lk_valid & lk_is_load & lk_hit &
                   ({1'b0, lk_conf} >= THRESH_EXT) & lfst_valid_reg[lk_ssid];
  assign st_disp = lk_valid & ~lk_is_load & lk_hit;

  assign l_idx   = pc_idx(viol_load_pc);
  assign s_idx   = pc_idx(viol_store_pc);
  assign f_idx   = pc_idx(fdep_load_pc);
  assign l_valid = ssit_valid_reg[l_idx];
  assign s_valid = ssit_valid_reg[s_idx];
  assign l_ssid  = ssit_ssid_reg[l_idx];
  assign s_ssid  = ssit_ssid_reg[s_idx];
  assign l_conf  = ssit_conf_reg[l_idx];
  assign s_conf  = ssit_conf_reg[s_idx];
  assign f_conf  = ssit_conf_reg[f_idx];

  // Merge rule for a violation; L==S falls out naturally since both reads agree.
  always_comb begin
    viol_ssid = alloc_ptr_reg;
    case ({l_valid, s_valid})
      2'b11:   viol_ssid = (l_ssid < s_ssid) ? l_ssid : s_ssid;
      2'b10:   viol_ssid = l_ssid;
      2'b01:   viol_ssid = s_ssid;
      default: viol_ssid = alloc_ptr_reg;
    endcase
  end

  assign l_conf_new = l_valid ? conf_inc(l_conf) : CONF_WIDTH'(1);
  assign s_conf_new = s_valid ? conf_inc(s_conf) : CONF_WIDTH'(1);
  assign alloc_take = viol_valid & ~l_valid & ~s_valid & ~clear_now;

  // False dependencies only weaken entries that are currently valid.
  assign fdep_act   = fdep_valid & ssit_valid_reg[f_idx];
  assign f_conf_dec = (f_conf == '0) ? '0 : f_conf - CONF_WIDTH'(1);

  assign sd_match = st_done_valid & lfst_valid_reg[st_done_ssid] &
                    (lfst_tag_reg[st_done_ssid] == st_done_tag);

  // Free-running flush timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clr_cnt_reg <= '0;
    else if (CLEAR_INTERVAL != 0)
      clr_cnt_reg <= clear_now ? '0 : clr_cnt_reg + CLR_W'(1);
  end

  // SSID allocator advances only when a violation creates a brand-new set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alloc_ptr_reg <= '0;
    else if (alloc_take)
      alloc_ptr_reg <= alloc_ptr_reg + SSID_W'(1);
  end

  // SSIT valid bits: flush beats violation, violation beats false dependency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssit_valid_reg <= '0;
    end else if (clear_now) begin
      ssit_valid_reg <= '0;
    end else begin
      if (fdep_act)
        ssit_valid_reg[f_idx] <= (f_conf_dec != '0);
      if (viol_valid) begin
        ssit_valid_reg[l_idx] <= 1'b1;
        ssit_valid_reg[s_idx] <= 1'b1;
      end
    end
  end

  // SSIT payload: later assignments (violation) override the fdep write.
  always_ff @(posedge clk) begin
    if (!clear_now) begin
      if (fdep_act)
        ssit_conf_reg[f_idx] <= f_conf_dec;
      if (viol_valid) begin
        ssit_ssid_reg[l_idx] <= viol_ssid;
        ssit_conf_reg[l_idx] <= l_conf_new;
        ssit_ssid_reg[s_idx] <= viol_ssid;
        ssit_conf_reg[s_idx] <= s_conf_new;
      end
    end
  end

  // LFST valid bits: dispatch of a newer store beats retirement of an older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfst_valid_reg <= '0;
    end else if (clear_now) begin
      lfst_valid_reg <= '0;
    end else begin
      if (sd_match)
        lfst_valid_reg[st_done_ssid] <= 1'b0;
      if (st_disp)
        lfst_valid_reg[lk_ssid] <= 1'b1;
    end
  end

  // LFST tag payload records the dispatching store.
  always_ff @(posedge clk) begin
    if (st_disp)
      lfst_tag_reg[lk_ssid] <= lk_tag;
  end

  // Registered lookup response; fields are zeroed when not meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_ssid_reg  <= '0;
      rsp_pred_reg  <= 1'b0;
      rsp_tag_reg   <= '0;
    end else begin
      rsp_valid_reg <= lk_valid;
      rsp_ssid_reg  <= (lk_valid & lk_hit) ? lk_ssid : '0;
      rsp_pred_reg  <= lk_pred;
      rsp_tag_reg   <= lk_pred ? lfst_tag_reg[lk_ssid] : '0;
    end
  end

  assign rsp_valid       = rsp_valid_reg;
  assign rsp_ssid        = rsp_ssid_reg;
  assign rsp_predict_dep = rsp_pred_reg;
  assign rsp_dep_tag     = rsp_tag_reg;

  // Saturating event counters: lookups, predictions, violations, flushes.
  logic [3:0] stat_inc;
  assign stat_inc = {clear_now, viol_valid, lk_pred, lk_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      logic [31:0] cnt_reg;
      // One counter per event, holding at all-ones.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= '0;
        else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF))
          cnt_reg <= cnt_reg + 32'd1;
      end
    end
  endgenerate

  assign stat_lookups     = g_stat[0].cnt_reg;
  assign stat_predictions = g_stat[1].cnt_reg;
  assign stat_violations  = g_stat[2].cnt_reg;
  assign stat_clears      = g_stat[3].cnt_reg;

endmodule

// File: tb/tb_store_set_predictor.sv
// Bench for store_set_predictor: table-driven vectors with a response scoreboard,
// plus hand-written sequences for asynchronous reset and the periodic flush.
module tb_store_set_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default flush interval, effectively never within this run).
  logic        lk_valid, lk_is_load;
  logic [31:0] lk_pc;
  logic [5:0]  lk_tag;
  logic        rsp_valid, rsp_predict_dep;
  logic [5:0]  rsp_ssid, rsp_dep_tag;
  logic        st_done_valid;
  logic [5:0]  st_done_ssid, st_done_tag;
  logic        viol_valid;
  logic [31:0] viol_load_pc, viol_store_pc;
  logic        fdep_valid;
  logic [31:0] fdep_load_pc;
  logic [31:0] stat_lookups, stat_predictions, stat_violations, stat_clears;

  // Short-interval instance for the flush scenario.
  logic        c_lk_valid, c_lk_is_load;
  logic [31:0] c_lk_pc;
  logic [5:0]  c_lk_tag;
  logic        c_rsp_valid, c_rsp_predict_dep;
  logic [5:0]  c_rsp_ssid, c_rsp_dep_tag;
  logic        c_viol_valid;
  logic [31:0] c_viol_load_pc, c_viol_store_pc;
  logic [31:0] c_stat_lookups, c_stat_predictions, c_stat_violations, c_stat_clears;

  store_set_predictor u_dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_is_load(lk_is_load), .lk_pc(lk_pc), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_ssid(rsp_ssid), .rsp_predict_dep(rsp_predict_dep),
    .rsp_dep_tag(rsp_dep_tag),
    .st_done_valid(st_done_valid), .st_done_ssid(st_done_ssid), .st_done_tag(st_done_tag),
    .viol_valid(viol_valid), .viol_load_pc(viol_load_pc), .viol_store_pc(viol_store_pc),
    .fdep_valid(fdep_valid), .fdep_load_pc(fdep_load_pc),
    .stat_lookups(stat_lookups), .stat_predictions(stat_predictions),
    .stat_violations(stat_violations), .stat_clears(stat_clears)
  );

  store_set_predictor #(.CLEAR_INTERVAL(16)) u_clr (
    .clk(clk), .rst(rst),
    .lk_valid(c_lk_valid), .lk_is_load(c_lk_is_load), .lk_pc(c_lk_pc), .lk_tag(c_lk_tag),
    .rsp_valid(c_rsp_valid), .rsp_ssid(c_rsp_ssid), .rsp_predict_dep(c_rsp_predict_dep),
    .rsp_dep_tag(c_rsp_dep_tag),
    .st_done_valid(1'b0), .st_done_ssid(6'd0), .st_done_tag(6'd0),
    .viol_valid(c_viol_valid), .viol_load_pc(c_viol_load_pc), .viol_store_pc(c_viol_store_pc),
    .fdep_valid(1'b0), .fdep_load_pc(32'd0),
    .stat_lookups(c_stat_lookups), .stat_predictions(c_stat_predictions),
    .stat_violations(c_stat_violations), .stat_clears(c_stat_clears)
  );

  typedef struct packed {
    logic [5:0] ssid;
    logic       pred;
    logic [5:0] tag;
  } rsp_t;

  typedef enum logic [2:0] {OP_RST, OP_LK, OP_VIOL, OP_FDEP, OP_SDONE, OP_STAT} op_e;

  typedef struct {
    op_e         op;
    logic        is_load;
    logic [31:0] pc;
    logic [31:0] pc2;
    logic [5:0]  tag;
    logic [5:0]  ssid;
    int          rep;
    rsp_t        exp;
    int          st_lk;
    int          st_pr;
    int          st_vi;
  } vec_t;

  vec_t vecs[$];
  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- table builders ----
  function automatic vec_t blank(input op_e op);
    vec_t v;
    v.op = op; v.is_load = 1'b0; v.pc = '0; v.pc2 = '0; v.tag = '0; v.ssid = '0;
    v.rep = 1; v.exp = '0; v.st_lk = 0; v.st_pr = 0; v.st_vi = 0;
    return v;
  endfunction

  function automatic void add_rst();
    vecs.push_back(blank(OP_RST));
  endfunction

  function automatic void add_lk(input logic ld, input logic [31:0] pc, input logic [5:0] tag,
                                 input logic [5:0] es, input logic ep, input logic [5:0] et);
    vec_t v = blank(OP_LK);
    v.is_load = ld; v.pc = pc; v.tag = tag;
    v.exp.ssid = es; v.exp.pred = ep; v.exp.tag = et;
    vecs.push_back(v);
  endfunction

  function automatic void add_viol(input logic [31:0] lpc, input logic [31:0] spc, input int n);
    vec_t v = blank(OP_VIOL);
    v.pc = lpc; v.pc2 = spc; v.rep = n;
    vecs.push_back(v);
  endfunction

  function automatic void add_fdep(input logic [31:0] pc, input int n);
    vec_t v = blank(OP_FDEP);
    v.pc = pc; v.rep = n;
    vecs.push_back(v);
  endfunction

  function automatic void add_sdone(input logic [5:0] ssid, input logic [5:0] tag);
    vec_t v = blank(OP_SDONE);
    v.ssid = ssid; v.tag = tag;
    vecs.push_back(v);
  endfunction

  function automatic void add_stat(input int lk, input int pr, input int vi);
    vec_t v = blank(OP_STAT);
    v.st_lk = lk; v.st_pr = pr; v.st_vi = vi;
    vecs.push_back(v);
  endfunction

  // ---- drivers ----
  task automatic idle_inputs();
    lk_valid = 1'b0; lk_is_load = 1'b0; lk_pc = '0; lk_tag = '0;
    st_done_valid = 1'b0; st_done_ssid = '0; st_done_tag = '0;
    viol_valid = 1'b0; viol_load_pc = '0; viol_store_pc = '0;
    fdep_valid = 1'b0; fdep_load_pc = '0;
    c_lk_valid = 1'b0; c_lk_is_load = 1'b0; c_lk_pc = '0; c_lk_tag = '0;
    c_viol_valid = 1'b0; c_viol_load_pc = '0; c_viol_store_pc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Reset is released 1 time unit after an edge; the next drive samples on the following edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      OP_RST: do_reset();
      OP_LK: begin
        lk_valid = 1'b1; lk_is_load = v.is_load; lk_pc = v.pc; lk_tag = v.tag;
        exp_q.push_back(v.exp);
        step();
      end
      OP_VIOL: for (int r = 0; r < v.rep; r++) begin
        viol_valid = 1'b1; viol_load_pc = v.pc; viol_store_pc = v.pc2;
        step();
      end
      OP_FDEP: for (int r = 0; r < v.rep; r++) begin
        fdep_valid = 1'b1; fdep_load_pc = v.pc;
        step();
      end
      OP_SDONE: begin
        st_done_valid = 1'b1; st_done_ssid = v.ssid; st_done_tag = v.tag;
        step();
      end
      OP_STAT: begin
        check("stat_lookups", stat_lookups, v.st_lk);
        check("stat_predictions", stat_predictions, v.st_pr);
        check("stat_violations", stat_violations, v.st_vi);
      end
      default: ;
    endcase
  endtask

  // Scoreboard: every valid response is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got ssid=%0d pred=%0b tag=%0d, expected no response",
                   rsp_ssid, rsp_predict_dep, rsp_dep_tag);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          $display("rsp: ssid=%0d pred=%0b tag=%0d (exp ssid=%0d pred=%0b tag=%0d)",
                   rsp_ssid, rsp_predict_dep, rsp_dep_tag, e.ssid, e.pred, e.tag);
          check("rsp_ssid", rsp_ssid, e.ssid);
          check("rsp_predict_dep", rsp_predict_dep, e.pred);
          check("rsp_dep_tag", rsp_dep_tag, e.tag);
        end
      end else begin
        check("idle_rsp_zero", {rsp_ssid, rsp_predict_dep, rsp_dep_tag}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // A: reset state, first lookup
    add_rst();
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_stat(1, 0, 0);

    // B: train, store dispatch, prediction, store-done (match / stale), unhit store
    add_rst();
    add_viol(32'h1000, 32'h2000, 8);
    add_lk(1'b0, 32'h2000, 6'd5, 6'd0, 1'b0, 6'd0);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b1, 6'd5);
    add_sdone(6'd0, 6'd4);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b1, 6'd5);
    add_sdone(6'd0, 6'd5);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_lk(1'b0, 32'h5000, 6'd9, 6'd0, 1'b0, 6'd0);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_stat(6, 2, 8);

    // C: allocation, set merging, one-valid copy, L==S
    add_rst();
    add_viol(32'h1000, 32'h2000, 1);
    add_viol(32'h3000, 32'h4000, 1);
    add_viol(32'h3000, 32'h2000, 1);
    add_lk(1'b1, 32'h3000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_lk(1'b0, 32'h4000, 6'd0, 6'd1, 1'b0, 6'd0);
    add_viol(32'h5000, 32'h6000, 1);
    add_lk(1'b1, 32'h5000, 6'd0, 6'd2, 1'b0, 6'd0);
    add_viol(32'h7000, 32'h4000, 1);
    add_lk(1'b1, 32'h7000, 6'd0, 6'd1, 1'b0, 6'd0);
    add_viol(32'h8000, 32'h8000, 1);
    add_lk(1'b1, 32'h8000, 6'd0, 6'd3, 1'b0, 6'd0);
    add_stat(5, 0, 6);

    // D: false-dependency decay to invalid, retrain, aliasing through the hash
    add_rst();
    add_viol(32'h3000, 32'h4000, 1);
    add_viol(32'h1000, 32'h2000, 8);
    add_lk(1'b0, 32'h2000, 6'd7, 6'd1, 1'b0, 6'd0);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd1, 1'b1, 6'd7);
    add_fdep(32'h1000, 1);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd1, 1'b0, 6'd0);
    add_viol(32'h1000, 32'h2000, 1);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd1, 1'b1, 6'd7);
    add_fdep(32'h1000, 9);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_viol(32'h1000, 32'h2000, 1);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd1, 1'b0, 6'd0);
    add_viol(32'h1010, 32'h3000, 8);
    add_lk(1'b0, 32'h3000, 6'd3, 6'd0, 1'b0, 6'd0);
    add_lk(1'b1, 32'h0000, 6'd0, 6'd0, 1'b1, 6'd3);

    // E: confidence saturates at 15 and does not wrap
    add_rst();
    add_viol(32'h1000, 32'h2000, 20);
    add_lk(1'b0, 32'h2000, 6'd2, 6'd0, 1'b0, 6'd0);
    add_fdep(32'h1000, 7);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b1, 6'd2);
    add_fdep(32'h1000, 1);
    add_lk(1'b1, 32'h1000, 6'd0, 6'd0, 1'b0, 6'd0);
    add_stat(3, 1, 20);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // Asynchronous reset mid-operation; a lookup during reset yields nothing.
    step();
    mon_en = 1'b0;
    lk_valid = 1'b1; lk_is_load = 1'b1; lk_pc = 32'h1000;
    step();
    check("async_pre_rsp_valid", rsp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_stat_lookups", stat_lookups, 0);
    lk_valid = 1'b1; lk_is_load = 1'b1; lk_pc = 32'h1000;
    step();
    check("rst_cycle_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    step();
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_stat_lookups", stat_lookups, 0);
    mon_en = 1'b1;

    // Periodic flush on the CLEAR_INTERVAL=16 instance: flush edge is the 16th after release.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c_viol_valid = 1'b1; c_viol_load_pc = 32'h1000; c_viol_store_pc = 32'h2000;
      step();
    end
    c_lk_valid = 1'b1; c_lk_is_load = 1'b0; c_lk_pc = 32'h2000; c_lk_tag = 6'd5;
    step();
    for (int i = 0; i < 5; i++) step();
    c_lk_valid = 1'b1; c_lk_is_load = 1'b1; c_lk_pc = 32'h1000;
    step();
    check("clr_pre_pred", c_rsp_predict_dep, 1);
    check("clr_pre_tag", c_rsp_dep_tag, 5);
    check("clr_pre_stat_clears", c_stat_clears, 0);
    // Flush cycle: lookup sees old contents, the violation is discarded.
    c_lk_valid = 1'b1; c_lk_is_load = 1'b1; c_lk_pc = 32'h1000;
    c_viol_valid = 1'b1; c_viol_load_pc = 32'h5000; c_viol_store_pc = 32'h6000;
    step();
    check("clr_cycle_rsp_valid", c_rsp_valid, 1);
    check("clr_cycle_pred", c_rsp_predict_dep, 1);
    check("clr_cycle_tag", c_rsp_dep_tag, 5);
    check("clr_stat_clears", c_stat_clears, 1);
    c_lk_valid = 1'b1; c_lk_is_load = 1'b1; c_lk_pc = 32'h1000;
    step();
    check("clr_post_pred", c_rsp_predict_dep, 0);
    check("clr_post_tag", c_rsp_dep_tag, 0);
    c_lk_valid = 1'b1; c_lk_is_load = 1'b1; c_lk_pc = 32'h5000;
    step();
    check("clr_lost_viol_ssid", c_rsp_ssid, 0);
    check("clr_lost_viol_pred", c_rsp_predict_dep, 0);

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
